// File: rtl/ctrl_update_queue.sv
// ctrl_update_queue: in-order FIFO between control-instruction resolution and
// predictor training. Captures exeCtrl* results and drains one per cycle
// through a ready/valid port; pushes lost to a full queue are counted.
module ctrl_update_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 32,
    parameter int TYPE_W = 2,
    parameter int CTI_W  = 4,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    exeCtrlValid_i,
    input  logic [PC_W-1:0]         exeCtrlPC_i,
    input  logic [TYPE_W-1:0]       exeCtrlType_i,
    input  logic [PC_W-1:0]         exeCtrlNPC_i,
    input  logic                    exeCtrlDir_i,
    input  logic [CTI_W-1:0]        exeCtiID_i,
    output logic                    updValid_o,
    input  logic                    updReady_i,
    output logic [PC_W-1:0]         updPC_o,
    output logic [TYPE_W-1:0]       updType_o,
    output logic [PC_W-1:0]         updNPC_o,
    output logic                    updDir_o,
    output logic [CTI_W-1:0]        updCtiID_o,
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic                    full_o,
    output logic [DROP_W-1:0]       dropCount_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * PC_W + TYPE_W + 1 + CTI_W;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  count;
    logic [DROP_W-1:0] dropCount;

    logic              isFull;
    logic              doPop;
    logic              doPush;
    logic              doDrop;
    logic [ENT_W-1:0]  headEntry;
    logic [ENT_W-1:0]  newEntry;

    assign newEntry = {exeCtrlPC_i, exeCtrlType_i, exeCtrlNPC_i, exeCtrlDir_i, exeCtiID_i};

    // Handshake decode: a pop frees the slot a same-cycle push needs, so a
    // full queue only drops when the head is not being taken.
    always_comb begin
        isFull = (count == CNT_W'(DEPTH));
        doPop  = (count != '0) && updReady_i;
        doPush = exeCtrlValid_i && (!isFull || doPop);
        doDrop = exeCtrlValid_i && isFull && !doPop;
    end

    // Entry storage is deliberately not reset; writes are gated off during reset/flush.
    always_ff @(posedge clk) begin
        if (!reset && !flush_i && doPush) begin
            mem[tailPtr] <= newEntry;
        end
    end

    // Pointer, count and drop-counter update; reset outranks flush, flush outranks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            count     <= '0;
            dropCount <= '0;
        end else if (flush_i) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPush) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (doPop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count <= count + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count <= count - CNT_W'(1);
            end
            if (doDrop && (dropCount != '1)) begin
                dropCount <= dropCount + DROP_W'(1);
            end
        end
    end

    // Head payload is read combinationally; it is don't-care while the queue is empty.
    always_comb begin
        headEntry   = mem[headPtr];
        updValid_o  = (count != '0);
        {updPC_o, updType_o, updNPC_o, updDir_o, updCtiID_o} = headEntry;
        occupancy_o = count;
        full_o      = isFull;
        dropCount_o = dropCount;
    end

endmodule
